uivtc_gen: RTL and testbench

- Programmable video timing controller; generates the VS/HS/DE raster that drives the test-pattern generator (I_tpg_vs/hs/de) and the downstream splicer.
- Horizontal and vertical counters are gated by a run/stop state machine. Stopping only takes effect at a frame boundary, so downstream stages never see a truncated frame.
- Default timing is 1080p60 (148.5 MHz pixel clock).

---
 rtl/uivtc_pkg.sv | 31 +++
 rtl/uivtc_axis_cnt.sv | 28 ++
 rtl/uivtc_gen.sv | 133 +++++++++++++
 tb/tb_uivtc_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uivtc_pkg.sv
// rtl/uivtc_pkg.sv - shared state encoding, counter width and timing presets for the video timing controller
package uivtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vtc_state_e;

  localparam int VTC_CNT_W     = 12;
  localparam int VTC_MAX_TOTAL = 1 << VTC_CNT_W;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vtc_timing_t;

  localparam vtc_timing_t VTC_1080P = '{1920, 88, 44, 148, 1080, 4, 5, 36};
  localparam vtc_timing_t VTC_720P  = '{1280, 110, 40, 220, 720, 5, 5, 20};

  function automatic int vtc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/uivtc_axis_cnt.sv
// rtl/uivtc_axis_cnt.sv - wrap counter with enable, synchronous clear and terminal-value wrap flag
module uivtc_axis_cnt
  import uivtc_pkg::*;
#(
  parameter int W = VTC_CNT_W
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uivtc_gen.sv
// rtl/uivtc_gen.sv - programmable VS/HS/DE raster generator with frame-aligned run/stop control
// Optional x/y position outputs are built only when VTC_POS_OUT_EN is defined.
module uivtc_gen
  import uivtc_pkg::*;
#(
  parameter int H_ACTIVE = VTC_1080P.h_active,
  parameter int H_FP     = VTC_1080P.h_fp,
  parameter int H_SYNC   = VTC_1080P.h_sync,
  parameter int H_BP     = VTC_1080P.h_bp,
  parameter int V_ACTIVE = VTC_1080P.v_active,
  parameter int V_FP     = VTC_1080P.v_fp,
  parameter int V_SYNC   = VTC_1080P.v_sync,
  parameter int V_BP     = VTC_1080P.v_bp,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
)(
  input  logic I_vtc_clk,
  input  logic I_vtc_rstn,
  input  logic I_vtc_en,
  output logic O_vtc_vs,
  output logic O_vtc_hs,
  output logic O_vtc_de,
  output logic O_vtc_sof,
  output logic O_vtc_busy
`ifdef VTC_POS_OUT_EN
  ,
  output logic [VTC_CNT_W-1:0] O_vtc_x,
  output logic [VTC_CNT_W-1:0] O_vtc_y
`endif
);

  localparam int H_TOTAL  = vtc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = vtc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_BEG   = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_BEG + H_SYNC;
  localparam int VS_BEG   = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_BEG + V_SYNC;
  localparam logic [VTC_CNT_W-1:0] H_TERM = VTC_CNT_W'(H_TOTAL - 1);
  localparam logic [VTC_CNT_W-1:0] V_TERM = VTC_CNT_W'(V_TOTAL - 1);

  generate
    if (H_TOTAL > VTC_MAX_TOTAL || V_TOTAL > VTC_MAX_TOTAL) begin : g_bad_total
      $error("uivtc_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
    end
  endgenerate

  vtc_state_e state, state_nxt;
  logic [VTC_CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap;
  logic running;
  logic h_act, v_act, h_sync_win, v_sync_win;

  assign running = (state != ST_IDLE);

  uivtc_axis_cnt #(.W(VTC_CNT_W)) u_h_cnt (
    .clk   (I_vtc_clk),
    .rst_n (I_vtc_rstn),
    .en    (running),
    .clr   (!running),
    .term  (H_TERM),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  uivtc_axis_cnt #(.W(VTC_CNT_W)) u_v_cnt (
    .clk   (I_vtc_clk),
    .rst_n (I_vtc_rstn),
    .en    (h_wrap),
    .clr   (!running),
    .term  (V_TERM),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // v_wrap marks the last clock of the frame; only there may DRAIN fall back to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (I_vtc_en) state_nxt = ST_RUN;
      ST_RUN:   if (!I_vtc_en) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (I_vtc_en)    state_nxt = ST_RUN;
        else if (v_wrap) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign h_act      = int'(h_cnt) < H_ACTIVE;
  assign v_act      = int'(v_cnt) < V_ACTIVE;
  assign h_sync_win = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END);
  assign v_sync_win = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END);

  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      O_vtc_de   <= 1'b0;
      O_vtc_sof  <= 1'b0;
      O_vtc_busy <= 1'b0;
      O_vtc_hs   <= ~HS_POL;
      O_vtc_vs   <= ~VS_POL;
    end else begin
      O_vtc_de   <= running && h_act && v_act;
      O_vtc_sof  <= running && (h_cnt == '0) && (v_cnt == '0);
      O_vtc_busy <= running;
      O_vtc_hs   <= (running && h_sync_win) ? HS_POL : ~HS_POL;
      O_vtc_vs   <= (running && v_sync_win) ? VS_POL : ~VS_POL;
    end
  end

`ifdef VTC_POS_OUT_EN
  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      O_vtc_x <= '0;
      O_vtc_y <= '0;
    end else if (running && h_act && v_act) begin
      O_vtc_x <= h_cnt;
      O_vtc_y <= v_cnt;
    end else begin
      O_vtc_x <= '0;
      O_vtc_y <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_uivtc_gen.sv
// tb/tb_uivtc_gen.sv - scoreboard bench for uivtc_gen on a 24x8 (192-clock) raster
module tb_uivtc_gen;

  localparam int HT    = 24;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic vs, hs, de, sof, busy;
`ifdef VTC_POS_OUT_EN
  logic [11:0] x, y;
`endif

  always #5 clk = ~clk;

  uivtc_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .I_vtc_clk  (clk),
    .I_vtc_rstn (rstn),
    .I_vtc_en   (en),
    .O_vtc_vs   (vs),
    .O_vtc_hs   (hs),
    .O_vtc_de   (de),
    .O_vtc_sof  (sof),
    .O_vtc_busy (busy)
`ifdef VTC_POS_OUT_EN
    ,
    .O_vtc_x    (x),
    .O_vtc_y    (y)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mstate = 0;
  int mpos = 0;
  logic [28:0] sb_q[$];

  function automatic logic [28:0] model_out(input int st, input int pos);
    int h, v;
    logic r, d;
    logic [11:0] xe, ye;
    h = pos % HT;
    v = pos / HT;
    r = (st != 0);
    d = r && (h < 16) && (v < 4);
    xe = 12'd0;
    ye = 12'd0;
`ifdef VTC_POS_OUT_EN
    if (d) begin
      xe = 12'(h);
      ye = 12'(v);
    end
`endif
    return {d, r && h >= 18 && h < 21, r && v >= 5 && v < 7, r && pos == 0, r, xe, ye};
  endfunction

  function automatic logic [28:0] observed();
    logic [11:0] xo, yo;
    xo = 12'd0;
    yo = 12'd0;
`ifdef VTC_POS_OUT_EN
    xo = x;
    yo = y;
`endif
    return {de, hs, vs, sof, busy, xo, yo};
  endfunction

  task automatic step(input logic en_val);
    logic [28:0] exp_v, got_v;
    en = en_val;
    sb_q.push_back(model_out(mstate, mpos));
    if (mstate == 0) begin
      if (en_val) mstate = 1;
      mpos = 0;
    end else begin
      if (mstate == 1 && !en_val)                  mstate = 2;
      else if (mstate == 2 && en_val)              mstate = 1;
      else if (mstate == 2 && mpos == FRAME - 1)   mstate = 0;
      mpos = (mpos + 1) % FRAME;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    got_v = observed();
    exp_v = sb_q.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL scoreboard cyc=%0d got=%h exp=%h", cyc, got_v, exp_v);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    mstate = 0;
    mpos = 0;
  endtask

  task automatic wait_sof(input string name);
    int n;
    n = 0;
    while (!sof && n < 400) begin
      step(1'b1);
      n++;
    end
    checks++;
    if (!sof) begin
      errors++;
      $display("FAIL %s_sof_timeout got=0 exp=1", name);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({de, sof, busy, hs, vs} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000", {de, sof, busy, hs, vs});
    end
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 50; i++) step(1'b0);
    checks++;
    if ({de, sof, busy, hs, vs} !== 5'b0) begin
      errors++;
      $display("FAIL idle_outputs got=%b exp=00000", {de, sof, busy, hs, vs});
    end
  endtask

  task automatic test_start();
    int n_busy, n_sof;
    n_busy = -1;
    n_sof = -1;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1);
      if (busy && n_busy < 0) n_busy = i;
      if (sof && n_sof < 0) n_sof = i;
    end
    checks++;
    if (n_busy !== 2) begin
      errors++;
      $display("FAIL start_busy_latency got=%0d exp=2", n_busy);
    end
    checks++;
    if (n_sof !== 2) begin
      errors++;
      $display("FAIL start_sof_latency got=%0d exp=2", n_sof);
    end
  endtask

  task automatic test_raster();
    int de_cnt, hs_cnt, vs_cnt, bursts, burst, vs_rise, hs_rise;
    logic vs_prev, hs_prev, de_prev;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; bursts = 0; burst = 0;
    vs_rise = -1; hs_rise = -1;
    vs_prev = 1'b0; hs_prev = 1'b0; de_prev = 1'b0;
    wait_sof("raster");
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) step(1'b1);
      if (de) begin de_cnt++; burst++; end
      if (!de && de_prev) begin
        bursts++;
        checks++;
        if (burst !== 16) begin
          errors++;
          $display("FAIL de_line_len got=%0d exp=16", burst);
        end
        burst = 0;
      end
      if (hs) hs_cnt++;
      if (vs) vs_cnt++;
      if (hs && !hs_prev && hs_rise < 0) hs_rise = i;
      if (vs && !vs_prev && vs_rise < 0) vs_rise = i;
      de_prev = de; hs_prev = hs; vs_prev = vs;
    end
    checks++;
    if (de_cnt !== 64) begin errors++; $display("FAIL de_per_frame got=%0d exp=64", de_cnt); end
    checks++;
    if (bursts !== 4) begin errors++; $display("FAIL de_lines got=%0d exp=4", bursts); end
    checks++;
    if (hs_cnt !== 24) begin errors++; $display("FAIL hs_per_frame got=%0d exp=24", hs_cnt); end
    checks++;
    if (hs_rise !== 18) begin errors++; $display("FAIL hs_rise_pos got=%0d exp=18", hs_rise); end
    checks++;
    if (vs_cnt !== 48) begin errors++; $display("FAIL vs_per_frame got=%0d exp=48", vs_cnt); end
    checks++;
    if (vs_rise !== 120) begin errors++; $display("FAIL vs_rise_pos got=%0d exp=120", vs_rise); end
    step(1'b1);
    checks++;
    if (sof !== 1'b1) begin errors++; $display("FAIL sof_period got=%b exp=1", sof); end
  endtask

  task automatic test_drain();
    int n, sof_cnt;
    n = 0;
    while (mpos != 48 && n < 400) begin step(1'b1); n++; end
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while (busy && n < 400);
    checks++;
    if (n !== 145) begin errors++; $display("FAIL drain_busy_fall got=%0d exp=145", n); end
    sof_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      step(1'b0);
      if (sof) sof_cnt++;
    end
    checks++;
    if (sof_cnt !== 0) begin errors++; $display("FAIL drain_no_sof got=%0d exp=0", sof_cnt); end
  endtask

  task automatic test_gapless(input string name, input int drop_from, input int drop_to);
    int gap, busy_low;
    gap = 0;
    busy_low = 0;
    wait_sof(name);
    do begin
      step((mpos >= drop_from && mpos < drop_to) ? 1'b0 : 1'b1);
      gap++;
      if (!busy) busy_low++;
    end while (!sof && gap < 400);
    checks++;
    if (gap !== FRAME) begin errors++; $display("FAIL %s_sof_gap got=%0d exp=%0d", name, gap, FRAME); end
    checks++;
    if (busy_low !== 0) begin errors++; $display("FAIL %s_busy_low got=%0d exp=0", name, busy_low); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (mpos != 3 * HT + 5 && n < 400) begin step(1'b1); n++; end
    checks++;
    if (de !== 1'b1) begin errors++; $display("FAIL pre_reset_de got=%b exp=1", de); end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({de, sof, busy, hs, vs} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=00000", {de, sof, busy, hs, vs});
    end
`ifdef VTC_POS_OUT_EN
    checks++;
    if ({x, y} !== 24'd0) begin errors++; $display("FAIL async_reset_xy got=%h exp=0", {x, y}); end
`endif
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b0);
    wait_sof("restart");
    for (int i = 0; i < FRAME; i++) step(1'b1);
  endtask

  initial begin
    test_reset();
    test_start();
    test_raster();
    test_drain();
    test_gapless("reraise", 100, 110);
    test_gapless("back_to_back", 150, FRAME - 1);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
